lut_mem_nbank_pingpong: RTL and testbench

LUT_MEM_NBANK_PINGPONG -- requirements
Module: lut_mem_nbank_pingpong

---
 rtl/lut_mem_nbank_pingpong.sv | 143 ++++++++++++++
 tb/tb_lut_mem_nbank_pingpong.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_mem_nbank_pingpong.sv
// Ping-pong LUT memory: a serial loader fills the shadow buffer page by page
// while the active buffer serves single-cycle-latency page/word reads.
module lut_mem_nbank_pingpong #(
  parameter int QUAN_SIZE       = 3,
  parameter int BANK_INTERLEAVE = 4,
  parameter int PAGE_NUM        = 16,
  parameter int ADDR_BITWIDTH   = 4,
  parameter int SEL_BITWIDTH    = 2,
  localparam int PAGE_SIZE      = QUAN_SIZE * BANK_INTERLEAVE
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  input  logic [QUAN_SIZE-1:0]     wr_word_i,
  output logic                     wr_ready_o,
  input  logic                     swap_i,
  output logic                     shadow_full_o,
  output logic                     active_bank_o,
  output logic                     swap_err_o,
  input  logic                     rd_en_i,
  input  logic [ADDR_BITWIDTH-1:0] rd_addr_i,
  input  logic [SEL_BITWIDTH-1:0]  rd_sel_i,
  output logic [PAGE_SIZE-1:0]     rd_page_o,
  output logic [QUAN_SIZE-1:0]     rd_word_o,
  output logic                     rd_valid_o
);

  typedef enum logic {LOAD, FULL} load_state_t;

  load_state_t              state_reg;
  logic [SEL_BITWIDTH-1:0]  word_cnt_reg;
  logic [ADDR_BITWIDTH-1:0] page_cnt_reg;
  logic [PAGE_SIZE-1:0]     page_buf_reg;
  logic                     active_bank_reg;
  logic                     shadow_full_reg;
  logic                     swap_err_reg;
  logic [PAGE_SIZE-1:0]     rd_page_reg;
  logic [QUAN_SIZE-1:0]     rd_word_reg;
  logic                     rd_valid_reg;

  // Both buffers share one array; the MSB of the index selects the buffer.
  logic [PAGE_SIZE-1:0]     mem_reg [2*PAGE_NUM];

  logic [PAGE_SIZE-1:0]     page_next;
  logic [PAGE_SIZE-1:0]     mem_rd_data;
  logic [QUAN_SIZE-1:0]     rd_slot [BANK_INTERLEAVE];
  logic [QUAN_SIZE-1:0]     rd_word_next;
  logic [ADDR_BITWIDTH:0]   wr_idx;
  logic [ADDR_BITWIDTH:0]   rd_idx;
  logic                     wr_accept;
  logic                     page_done;
  logic                     last_page;

  assign wr_accept = wr_valid_i && (state_reg == LOAD);
  assign page_done = wr_accept && (word_cnt_reg == SEL_BITWIDTH'(BANK_INTERLEAVE - 1));
  assign last_page = (page_cnt_reg == ADDR_BITWIDTH'(PAGE_NUM - 1));
  assign wr_idx    = {~active_bank_reg, page_cnt_reg};
  assign rd_idx    = {active_bank_reg, rd_addr_i};
  assign mem_rd_data = mem_reg[rd_idx];

  // Word 0 lands in the most significant slot of the page.
  generate
    for (genvar gi = 0; gi < BANK_INTERLEAVE; gi++) begin : g_slot
      assign page_next[PAGE_SIZE-1-gi*QUAN_SIZE -: QUAN_SIZE] =
        (word_cnt_reg == SEL_BITWIDTH'(gi)) ? wr_word_i
                                            : page_buf_reg[PAGE_SIZE-1-gi*QUAN_SIZE -: QUAN_SIZE];
      assign rd_slot[gi] = mem_rd_data[PAGE_SIZE-1-gi*QUAN_SIZE -: QUAN_SIZE];
    end
  endgenerate

  // Selects beyond the last slot read back as zero.
  always_comb begin
    rd_word_next = '0;
    for (int k = 0; k < BANK_INTERLEAVE; k++) begin
      if (rd_sel_i == SEL_BITWIDTH'(k)) rd_word_next = rd_slot[k];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (page_done) mem_reg[wr_idx] <= page_next;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg       <= LOAD;
      word_cnt_reg    <= '0;
      page_cnt_reg    <= '0;
      page_buf_reg    <= '0;
      active_bank_reg <= 1'b0;
      shadow_full_reg <= 1'b0;
      swap_err_reg    <= 1'b0;
      rd_page_reg     <= '0;
      rd_word_reg     <= '0;
      rd_valid_reg    <= 1'b0;
    end else begin
      swap_err_reg <= 1'b0;
      rd_valid_reg <= rd_en_i;
      if (rd_en_i) begin
        rd_page_reg <= mem_rd_data;
        rd_word_reg <= rd_word_next;
      end
      case (state_reg)
        LOAD: begin
          if (swap_i) swap_err_reg <= 1'b1;
          if (wr_accept) begin
            page_buf_reg <= page_next;
            if (page_done) begin
              word_cnt_reg <= '0;
              page_cnt_reg <= page_cnt_reg + ADDR_BITWIDTH'(1);
              if (last_page) begin
                page_cnt_reg    <= '0;
                state_reg       <= FULL;
                shadow_full_reg <= 1'b1;
              end
            end else begin
              word_cnt_reg <= word_cnt_reg + SEL_BITWIDTH'(1);
            end
          end
        end
        FULL: begin
          // Words offered while full (even alongside a swap) are dropped.
          if (swap_i) begin
            active_bank_reg <= ~active_bank_reg;
            word_cnt_reg    <= '0;
            page_cnt_reg    <= '0;
            shadow_full_reg <= 1'b0;
            state_reg       <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign wr_ready_o    = (state_reg == LOAD);
  assign shadow_full_o = shadow_full_reg;
  assign active_bank_o = active_bank_reg;
  assign swap_err_o    = swap_err_reg;
  assign rd_page_o     = rd_page_reg;
  assign rd_word_o     = rd_word_reg;
  assign rd_valid_o    = rd_valid_reg;

endmodule

// File: tb/tb_lut_mem_nbank_pingpong.sv
// Directed bench for lut_mem_nbank_pingpong with a read scoreboard queue.
module tb_lut_mem_nbank_pingpong;

  localparam int Q  = 3;
  localparam int BI = 4;
  localparam int PN = 16;
  localparam int PS = Q * BI;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic [Q-1:0]  wr_word_i = '0;
  logic          wr_ready_o;
  logic          swap_i = 1'b0;
  logic          shadow_full_o;
  logic          active_bank_o;
  logic          swap_err_o;
  logic          rd_en_i = 1'b0;
  logic [3:0]    rd_addr_i = '0;
  logic [1:0]    rd_sel_i = '0;
  logic [PS-1:0] rd_page_o;
  logic [Q-1:0]  rd_word_o;
  logic          rd_valid_o;

  lut_mem_nbank_pingpong dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .wr_valid_i    (wr_valid_i),
    .wr_word_i     (wr_word_i),
    .wr_ready_o    (wr_ready_o),
    .swap_i        (swap_i),
    .shadow_full_o (shadow_full_o),
    .active_bank_o (active_bank_o),
    .swap_err_o    (swap_err_o),
    .rd_en_i       (rd_en_i),
    .rd_addr_i     (rd_addr_i),
    .rd_sel_i      (rd_sel_i),
    .rd_page_o     (rd_page_o),
    .rd_word_o     (rd_word_o),
    .rd_valid_o    (rd_valid_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [PS-1:0] page;
    logic [Q-1:0]  word;
  } exp_t;

  exp_t          exp_q[$];
  logic [PS-1:0] model [2][PN];
  logic [PS-1:0] pend;
  logic [PS-1:0] last_page;
  bit            act;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [Q-1:0] gen_word(input int mode, input int i);
    case (mode)
      0:       return Q'(i % 8);
      1:       return Q'(7 - (i % 8));
      default: return Q'($urandom_range(0, 7));
    endcase
  endfunction

  // Model packs by shifting: the first word of a page ends up in the MSBs.
  task automatic load_words(input int mode, input int first, input int n, input bit chk_full);
    logic [Q-1:0] v;
    for (int i = first; i < first + n; i++) begin
      v = gen_word(mode, i);
      check("wr_ready_load", 32'(wr_ready_o), 32'd1);
      wr_valid_i = 1'b1;
      wr_word_i  = v;
      tick();
      pend = {pend[PS-Q-1:0], v};
      if (i % BI == BI - 1) model[act ^ 1'b1][i / BI] = pend;
      if (chk_full) check($sformatf("shadow_full_w%0d", i), 32'(shadow_full_o), 32'(i == PN*BI-1));
    end
    wr_valid_i = 1'b0;
  endtask

  function automatic exp_t expect_rd(input int addr, input int sel);
    exp_t e;
    e.page = model[act][addr];
    e.word = Q'(e.page >> ((BI - 1 - sel) * Q));
    return e;
  endfunction

  task automatic issue_read(input int addr, input int sel);
    rd_en_i   = 1'b1;
    rd_addr_i = 4'(addr);
    rd_sel_i  = 2'(sel);
    exp_q.push_back(expect_rd(addr, sel));
    tick();
    rd_en_i = 1'b0;
  endtask

  // Scoreboard: every valid read pops the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (rd_valid_o) begin
        check("rd_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rd_page", 32'(rd_page_o), 32'(e.page));
          check("rd_word", 32'(rd_word_o), 32'(e.word));
          last_page = e.page;
        end
      end
    end
  end

  initial begin
    act = 1'b0;
    pend = '0;
    last_page = '0;

    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wr_ready", 32'(wr_ready_o), 32'd1);
    check("rst_shadow_full", 32'(shadow_full_o), 32'd0);
    check("rst_active", 32'(active_bank_o), 32'd0);
    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("rst_rd_page", 32'(rd_page_o), 32'd0);
    check("rst_rd_word", 32'(rd_word_o), 32'd0);
    check("rst_swap_err", 32'(swap_err_o), 32'd0);

    // First load: i%8
    load_words(0, 0, PN*BI, 1'b1);

    // Writes while full are ignored
    for (int c = 0; c < 3; c++) begin
      wr_valid_i = 1'b1;
      wr_word_i  = 3'd5;
      tick();
      check("full_wr_ready", 32'(wr_ready_o), 32'd0);
      check("full_shadow_full", 32'(shadow_full_o), 32'd1);
    end
    wr_valid_i = 1'b0;

    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
    act = 1'b1;
    check("swap1_active", 32'(active_bank_o), 32'd1);
    check("swap1_shadow_full", 32'(shadow_full_o), 32'd0);
    check("swap1_wr_ready", 32'(wr_ready_o), 32'd1);

    for (int s = 0; s < BI; s++) issue_read(0, s);
    check("page0_const", 32'(rd_page_o), 32'h053);
    for (int s = 0; s < BI; s++) issue_read(PN - 1, s);
    tick();
    check("idle_rd_valid", 32'(rd_valid_o), 32'd0);
    check("idle_rd_page_hold", 32'(rd_page_o), 32'(last_page));

    // Swap during load is rejected
    load_words(1, 0, 10, 1'b0);
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
    check("swap_err_pulse", 32'(swap_err_o), 32'd1);
    check("swap_err_active", 32'(active_bank_o), 32'd1);
    tick();
    check("swap_err_clear", 32'(swap_err_o), 32'd0);
    load_words(1, 10, PN*BI - 10, 1'b1);

    // Swap with coincident read and write; read sees the old buffer
    swap_i     = 1'b1;
    wr_valid_i = 1'b1;
    wr_word_i  = 3'd2;
    rd_en_i    = 1'b1;
    rd_addr_i  = 4'd0;
    rd_sel_i   = 2'd0;
    exp_q.push_back(expect_rd(0, 0));
    tick();
    swap_i = 1'b0;
    wr_valid_i = 1'b0;
    rd_en_i = 1'b0;
    act = 1'b0;
    check("swap2_active", 32'(active_bank_o), 32'd0);
    check("swap2_rd_page_old", 32'(rd_page_o), 32'h053);
    check("swap2_shadow_full", 32'(shadow_full_o), 32'd0);
    issue_read(0, 0);
    check("swap2_rd_page_new", 32'(rd_page_o), 32'hFAC);

    // Reset mid-load, then a full reload
    load_words(2, 0, 10, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_active", 32'(active_bank_o), 32'd0);
    check("rst2_shadow_full", 32'(shadow_full_o), 32'd0);
    load_words(2, 0, PN*BI, 1'b1);
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
    act = 1'b1;
    check("swap3_active", 32'(active_bank_o), 32'd1);
    for (int p = 0; p < PN; p++) issue_read(p, $urandom_range(0, BI - 1));

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
